// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending front-end.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    localparam int EDGE  = 1;
    localparam int LEVEL = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [N_IRQ-1:0] id_to_mask(input logic [ID_W-1:0] id);
        return N_IRQ'(1) << id;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Vector handshake between the interrupt front-end (master) and its consumer (slave).
interface irq_pending_ctrl_if;
    import irq_pkg::*;

    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ready;

    modport master (output irq_valid, output irq_id, input irq_ready);
    modport slave  (input irq_valid, input irq_id, output irq_ready);

endinterface

// File: rtl/irq_prio_sel.sv
// 8-to-3 priority select: highest set index wins, id is 0 when nothing is set.
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    always_comb begin
        id_o  = '0;
        any_o = |req_i;
        for (int i = 0; i < N_IRQ; i++) begin
            if (req_i[i]) id_o = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronise raw lines, capture into pending, present the
// highest unmasked pending index on a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no vector presented; waiting for an unmasked pending bit
//   PRESENT | irq_id/irq_valid frozen until the consumer accepts
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IRQ-1:0]     irq_in,
    input  logic [N_IRQ-1:0]     mask,
    input  logic                 clear_all,
    irq_pending_ctrl_if.master   irq_bus,
    output logic [N_IRQ-1:0]     pending
);

    logic [N_IRQ-1:0] sync;
    logic [N_IRQ-1:0] sync_d_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] set, clr, masked;
    logic [ID_W-1:0]  sel_id;
    logic             sel_any;
    logic             handshake;
    state_t           state_q;
    logic             valid_q;
    logic [ID_W-1:0]  id_q;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chain_q <= '0;
            else        chain_q <= {chain_q[SYNC_STAGES-2:0], irq_in[i]};
        end

        assign sync[i] = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_d_q <= '0;
        else        sync_d_q <= sync;
    end

    assign set       = (EDGE_MODE == EDGE) ? (sync & ~sync_d_q) : sync;
    assign handshake = (state_q == PRESENT) && irq_bus.irq_ready;
    assign clr       = handshake ? id_to_mask(id_q) : '0;

    // A line that re-fires on the very edge it is serviced must not be lost.
    always_comb begin
        pending_d = (pending_q | set) & ~(clr & ~set);
        if (clear_all) pending_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign masked = pending_q & mask;

    irq_prio_sel u_prio_sel (
        .req_i (masked),
        .id_o  (sel_id),
        .any_o (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else if (clear_all) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                        id_q    <= sel_id;
                    end
                end
                PRESENT: begin
                    if (irq_bus.irq_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_bus.irq_valid = valid_q;
    assign irq_bus.irq_id    = id_q;
    assign pending           = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge-mode and level-mode instances,
// accepted vector ids checked against a scoreboard queue.
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IRQ-1:0] irq_in_e, mask_e, pending_e;
    logic [N_IRQ-1:0] irq_in_l, mask_l, pending_l;
    logic             clear_e, clear_l;

    irq_pending_ctrl_if ife ();
    irq_pending_ctrl_if ifl ();

    irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(EDGE)) u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in_e),
        .mask      (mask_e),
        .clear_all (clear_e),
        .irq_bus   (ife),
        .pending   (pending_e)
    );

    irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(LEVEL)) u_lvl (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in_l),
        .mask      (mask_l),
        .clear_all (clear_l),
        .irq_bus   (ifl),
        .pending   (pending_l)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int q_e[$];
    int q_l[$];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ife.irq_valid && ife.irq_ready) begin
                checks++;
                if (q_e.size() == 0) begin
                    errors++;
                    $display("FAIL hs_edge: got id %0d expected none at %0t", ife.irq_id, $time);
                end else begin
                    int exp_id;
                    exp_id = q_e.pop_front();
                    if (int'(ife.irq_id) != exp_id) begin
                        errors++;
                        $display("FAIL hs_edge: got id %0d expected %0d at %0t", ife.irq_id, exp_id, $time);
                    end
                end
            end
            if (ifl.irq_valid && ifl.irq_ready) begin
                checks++;
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL hs_lvl: got id %0d expected none at %0t", ifl.irq_id, $time);
                end else begin
                    int exp_id;
                    exp_id = q_l.pop_front();
                    if (int'(ifl.irq_id) != exp_id) begin
                        errors++;
                        $display("FAIL hs_lvl: got id %0d expected %0d at %0t", ifl.irq_id, exp_id, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        irq_in_e      = 8'hFF;
        mask_e        = 8'h00;
        clear_e       = 1'b0;
        irq_in_l      = 8'h00;
        mask_l        = 8'hFF;
        clear_l       = 1'b0;
        ife.irq_ready = 1'b0;
        ifl.irq_ready = 1'b0;

        // 1: reset holds everything at zero even with all lines high
        cyc(3);
        chk("rst_pending", pending_e, 8'h00);
        chk("rst_valid", {7'd0, ife.irq_valid}, 8'h00);
        chk("rst_id", {5'd0, ife.irq_id}, 8'h00);
        chk("rst_valid_lvl", {7'd0, ifl.irq_valid}, 8'h00);
        rst_n = 1'b1;
        cyc(2);
        chk("latency_2cyc", pending_e, 8'h00);
        cyc(1);
        chk("latency_3cyc", pending_e, 8'hFF);
        irq_in_e = 8'h00;
        clear_e  = 1'b1;
        cyc(1);
        clear_e  = 1'b0;
        cyc(3);
        chk("flush_init", pending_e, 8'h00);

        // 2: simultaneous 2 and 5, ready held high
        mask_e = 8'hFF;
        q_e.push_back(5);
        q_e.push_back(2);
        ife.irq_ready = 1'b1;
        irq_in_e = 8'h24;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(8);
        ife.irq_ready = 1'b0;
        chk("prio_pending", pending_e, 8'h00);
        chk("prio_valid", {7'd0, ife.irq_valid}, 8'h00);

        // 3: presented id holds while a higher line arrives
        q_e.push_back(3);
        q_e.push_back(7);
        irq_in_e = 8'h08;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(4);
        chk("hold_valid0", {7'd0, ife.irq_valid}, 8'h01);
        chk("hold_id0", {5'd0, ife.irq_id}, 8'h03);
        irq_in_e = 8'h80;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(5);
        chk("hold_valid1", {7'd0, ife.irq_valid}, 8'h01);
        chk("hold_id1", {5'd0, ife.irq_id}, 8'h03);
        chk("hold_pending", pending_e, 8'h88);
        ife.irq_ready = 1'b1;
        cyc(4);
        ife.irq_ready = 1'b0;
        chk("hold_pending_end", pending_e, 8'h00);
        chk("hold_valid_end", {7'd0, ife.irq_valid}, 8'h00);

        // 4: masked bit stays pending, presents once unmasked
        mask_e = 8'hEF;
        irq_in_e = 8'h10;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(5);
        chk("mask_pending", pending_e, 8'h10);
        chk("mask_valid", {7'd0, ife.irq_valid}, 8'h00);
        mask_e = 8'hFF;
        q_e.push_back(4);
        cyc(1);
        chk("unmask_valid", {7'd0, ife.irq_valid}, 8'h01);
        chk("unmask_id", {5'd0, ife.irq_id}, 8'h04);
        ife.irq_ready = 1'b1;
        cyc(2);
        ife.irq_ready = 1'b0;
        chk("unmask_pending_end", pending_e, 8'h00);

        // 5: new edge on line 6 lands on the edge id 6 is accepted
        q_e.push_back(6);
        q_e.push_back(6);
        irq_in_e = 8'h40;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(4);
        chk("coll_id", {5'd0, ife.irq_id}, 8'h06);
        irq_in_e = 8'h40;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(1);
        ife.irq_ready = 1'b1;
        cyc(1);
        ife.irq_ready = 1'b0;
        chk("coll_pending", pending_e, 8'h40);
        chk("coll_valid_bubble", {7'd0, ife.irq_valid}, 8'h00);
        cyc(1);
        chk("coll_valid_again", {7'd0, ife.irq_valid}, 8'h01);
        chk("coll_id_again", {5'd0, ife.irq_id}, 8'h06);
        ife.irq_ready = 1'b1;
        cyc(2);
        ife.irq_ready = 1'b0;
        chk("coll_pending_end", pending_e, 8'h00);

        // 6a: clear_all drops a presented vector without handshake
        irq_in_e = 8'h02;
        cyc(1);
        irq_in_e = 8'h00;
        cyc(4);
        chk("flush_valid_pre", {7'd0, ife.irq_valid}, 8'h01);
        clear_e = 1'b1;
        cyc(1);
        clear_e = 1'b0;
        chk("flush_valid", {7'd0, ife.irq_valid}, 8'h00);
        chk("flush_pending", pending_e, 8'h00);
        cyc(3);
        chk("flush_stays_idle", {7'd0, ife.irq_valid}, 8'h00);

        // 6b: level mode, line 1 held high re-presents after each accept
        irq_in_l = 8'h02;
        cyc(5);
        chk("lvl_valid", {7'd0, ifl.irq_valid}, 8'h01);
        chk("lvl_id", {5'd0, ifl.irq_id}, 8'h01);
        q_l.push_back(1);
        q_l.push_back(1);
        q_l.push_back(1);
        ifl.irq_ready = 1'b1;
        cyc(5);
        ifl.irq_ready = 1'b0;
        chk("lvl_pending_kept", pending_l, 8'h02);
        cyc(1);
        chk("lvl_valid_again", {7'd0, ifl.irq_valid}, 8'h01);
        chk("lvl_id_again", {5'd0, ifl.irq_id}, 8'h01);
        irq_in_l = 8'h00;
        cyc(3);

        chk("sb_edge_drained", 8'(q_e.size()), 8'h00);
        chk("sb_lvl_drained", 8'(q_l.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
